tinker_mem_dualport: RTL

//  Parametrised two-port byte-addressed memory for the Tinker core: instruction-fetch port (read-only) and data port (load/store).

---
 rtl/tinker_mem_pkg.sv | 31 +++
 rtl/mem_port_fsm.sv | 82 ++++++++
 rtl/tinker_mem_dualport.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types and helpers for the Tinker two-port memory.
// Port FSM states, counter sizing and the address fault check.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        MP_IDLE,
        MP_WAIT,
        MP_RESP
    } mem_port_state_t;

    localparam int MP_LATENCY_DEF = 2;

    function automatic int mp_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

    // Sum is one bit wider than the address so a high address cannot wrap.
    function automatic logic addr_fault(
        input logic [63:0] addr,
        input int          bytes,
        input logic [63:0] mem_bytes,
        input logic        check_align
    );
        logic [64:0] w_end;
        logic        w_mis;
        w_end = {1'b0, addr} + 65'(bytes);
        w_mis = check_align && ((addr % 64'(bytes)) != 64'd0);
        return (w_end > {1'b0, mem_bytes}) || w_mis;
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One request/response port: accept handshake, latency counter,
// and the held response data/error register.
module mem_port_fsm
    import tinker_mem_pkg::*;
#(
    parameter int LATENCY = MP_LATENCY_DEF,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req_valid,
    input  logic         i_resp_ready,
    input  logic [W-1:0] i_rdata,
    input  logic         i_err,
    output logic         o_req_ready,
    output logic         o_accept,
    output logic         o_resp_valid,
    output logic [W-1:0] o_resp_data,
    output logic         o_resp_err
);

    localparam int CW = mp_cnt_w(LATENCY);

    mem_port_state_t r_state;
    mem_port_state_t w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_data;
    logic            r_err;
    logic            w_release;

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_accept     = 1'b0;
        o_resp_valid = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            MP_IDLE: begin
                o_req_ready = 1'b1;
                // A request seen while reset is held is never taken.
                o_accept    = i_req_valid && !reset;
                if (o_accept) w_next = MP_WAIT;
            end
            MP_WAIT: begin
                if (r_cnt == '0) w_next = MP_RESP;
            end
            MP_RESP: begin
                o_resp_valid = 1'b1;
                w_release    = i_resp_ready;
                if (i_resp_ready) w_next = MP_IDLE;
            end
            default: w_next = MP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MP_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (o_accept) begin
                r_cnt  <= CW'(LATENCY - 1);
                r_data <= i_rdata;
                r_err  <= i_err;
            end else begin
                if (r_state == MP_WAIT && r_cnt != '0)
                    r_cnt <= r_cnt - CW'(1);
                if (w_release) begin
                    r_data <= '0;
                    r_err  <= 1'b0;
                end
            end
        end
    end

    assign o_resp_data = r_data;
    assign o_resp_err  = r_err;

endmodule

// File: rtl/tinker_mem_dualport.sv
// Tinker core memory: byte array behind a fetch port and a load/store
// port, each with fixed latency and one outstanding request.
module tinker_mem_dualport
    import tinker_mem_pkg::*;
#(
    parameter int MEM_BYTES   = 524288,
    parameter int ADDR_W      = 32,
    parameter int INST_W      = 32,
    parameter int DATA_W      = 64,
    parameter int LATENCY     = MP_LATENCY_DEF,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [INST_W-1:0] if_resp_data,
    output logic              if_resp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic              d_resp_err
);

    localparam int IB    = INST_W / 8;
    localparam int DB    = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);

    logic [7:0] r_mem [MEM_BYTES];

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_d_idx;
    logic              w_if_fault;
    logic              w_d_fault;
    logic [INST_W-1:0] w_if_rd;
    logic [DATA_W-1:0] w_d_rd;
    logic [DATA_W-1:0] w_d_resp;
    logic              w_if_accept;
    logic              w_d_accept;
    logic              w_d_wr;

    assign w_if_idx = if_addr[IDX_W-1:0];
    assign w_d_idx  = d_addr[IDX_W-1:0];

    assign w_if_fault = addr_fault(64'(if_addr), IB,
                                   64'(MEM_BYTES), CHECK_ALIGN != 0);
    assign w_d_fault  = addr_fault(64'(d_addr), DB,
                                   64'(MEM_BYTES), CHECK_ALIGN != 0);

    // Little-endian gather; faulting accesses return zero.
    always_comb begin
        w_if_rd = '0;
        for (int k = 0; k < IB; k++)
            w_if_rd[8*k +: 8] = r_mem[w_if_idx + IDX_W'(k)];
        if (w_if_fault) w_if_rd = '0;
    end

    always_comb begin
        w_d_rd = '0;
        for (int k = 0; k < DB; k++)
            w_d_rd[8*k +: 8] = r_mem[w_d_idx + IDX_W'(k)];
        if (w_d_fault) w_d_rd = '0;
    end

    assign w_d_resp = d_req_we ? '0 : w_d_rd;
    assign w_d_wr   = w_d_accept && d_req_we && !w_d_fault;

    // Reads sample before this edge commits, so a same-edge read sees old bytes.
    always_ff @(posedge clk) begin
        if (w_d_wr) begin
            for (int k = 0; k < DB; k++)
                r_mem[w_d_idx + IDX_W'(k)] <= d_wdata[8*k +: 8];
        end
    end

    mem_port_fsm #(
        .LATENCY (LATENCY),
        .W       (INST_W)
    ) u_if_port (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (if_req_valid),
        .i_resp_ready (if_resp_ready),
        .i_rdata      (w_if_rd),
        .i_err        (w_if_fault),
        .o_req_ready  (if_req_ready),
        .o_accept     (w_if_accept),
        .o_resp_valid (if_resp_valid),
        .o_resp_data  (if_resp_data),
        .o_resp_err   (if_resp_err)
    );

    mem_port_fsm #(
        .LATENCY (LATENCY),
        .W       (DATA_W)
    ) u_d_port (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (d_req_valid),
        .i_resp_ready (d_resp_ready),
        .i_rdata      (w_d_resp),
        .i_err        (w_d_fault),
        .o_req_ready  (d_req_ready),
        .o_accept     (w_d_accept),
        .o_resp_valid (d_resp_valid),
        .o_resp_data  (d_resp_rdata),
        .o_resp_err   (d_resp_err)
    );

    logic w_unused;
    assign w_unused = w_if_accept;

endmodule
